ir_fetch_ctrl: RTL

- Instruction-fetch sequencer that sits directly upstream of the instruction register (ir).
- Owns the program counter and reads two consecutive bytes from 8-bit memory.
- Steers each byte into the 16-bit IR through the ir load/half-select controls (ir_enable, ir_funsel, ir_lh), then signals completion to the control unit.
- Memory may insert any number of wait states.

---
 rtl/ir_fetch_ctrl.sv | 88 ++++++++
 1 files changed

// File: rtl/ir_fetch_ctrl.sv
// Two-byte instruction fetch sequencer feeding the 16-bit IR.
// Owns the PC; tolerates any number of memory wait states.
module ir_fetch_ctrl #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_start,
    output logic          fetch_busy,
    output logic          fetch_done,
    input  logic          pc_load,
    input  logic [AW-1:0] pc_in,
    output logic [AW-1:0] pc_out,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_data,
    input  logic          mem_rdy,
    output logic [DW-1:0] ir_data,
    output logic          ir_enable,
    output logic [1:0]    ir_funsel,
    output logic          ir_lh
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_LO = 2'd1,
        RD_HI = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] pc, pc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        fetch_busy = 1'b0;
        fetch_done = 1'b0;
        mem_rd     = 1'b0;
        ir_enable  = 1'b0;
        ir_lh      = 1'b0;
        ir_data    = '0;
        unique case (state)
            IDLE: begin
                if (pc_load) pc_nxt = pc_in;
                if (fetch_start) state_nxt = RD_LO;
            end
            RD_LO, RD_HI: begin
                fetch_busy = 1'b1;
                mem_rd     = 1'b1;
                ir_lh      = (state == RD_HI);
                // An abort wins over a byte arriving in the same cycle.
                if (pc_load) begin
                    pc_nxt    = pc_in;
                    state_nxt = IDLE;
                end else if (mem_rdy) begin
                    ir_enable = 1'b1;
                    ir_data   = mem_data;
                    pc_nxt    = pc + 1'b1;
                    state_nxt = (state == RD_HI) ? DONE : RD_HI;
                end
            end
            DONE: begin
                fetch_done = 1'b1;
                if (pc_load) pc_nxt = pc_in;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ir_funsel = {1'b0, ir_enable};
    assign pc_out    = pc;
    assign mem_addr  = pc;

endmodule
